// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry adder/subtractor, CHUNK bits per stage, valid/ready handshake.
// Define ADDER_PIPE_FLAGS_EN to compute and register overflow_o and zero_o (tied to 0 otherwise).

module adder_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sub_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic w_stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added shrink by CHUNK per stage; result bits grow by CHUNK.
        localparam int IN_W  = WIDTH - k * CHUNK;
        localparam int RES_W = (k + 1) * CHUNK;

        logic [IN_W-1:0]  w_a;
        logic [IN_W-1:0]  w_b;
        logic             w_cin;
        logic             w_vin;
        logic [CHUNK:0]   w_sum;
        logic [RES_W-1:0] w_res;
        logic             r_valid;
        logic             r_carry;
        logic [RES_W-1:0] r_res;

        if (k == 0) begin : g_head
            assign w_a   = a_i;
            assign w_b   = sub_i ? ~b_i : b_i;
            assign w_cin = carry_i ^ sub_i;
            assign w_vin = in_valid_i;
            assign w_res = w_sum[CHUNK-1:0];
        end else begin : g_body
            assign w_a   = g_stage[k-1].g_fwd.r_a;
            assign w_b   = g_stage[k-1].g_fwd.r_b;
            assign w_cin = g_stage[k-1].r_carry;
            assign w_vin = g_stage[k-1].r_valid;
            assign w_res = {w_sum[CHUNK-1:0], g_stage[k-1].r_res};
        end

        assign w_sum = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_cin};

        // NOTE: datapath registers are reset as well as valid bits, so res_o and carry_o read 0 out of reset.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_res   <= '0;
            end else if (!w_stall) begin
                r_valid <= w_vin;
                r_carry <= w_sum[CHUNK];
                r_res   <= w_res;
            end
        end

        if (IN_W > CHUNK) begin : g_fwd
            logic [IN_W-CHUNK-1:0] r_a;
            logic [IN_W-CHUNK-1:0] r_b;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_a[IN_W-1:CHUNK];
                    r_b <= w_b[IN_W-1:CHUNK];
                end
            end
        end
    end

    // A full output register that is not being drained freezes the whole pipe.
    assign w_stall     = g_stage[LAST].r_valid && !out_ready_i;
    assign in_ready_o  = !w_stall;
    assign out_valid_o = g_stage[LAST].r_valid;
    assign res_o       = g_stage[LAST].r_res;
    assign carry_o     = g_stage[LAST].r_carry;

`ifdef ADDER_PIPE_FLAGS_EN
    logic w_ovf;
    logic w_zero;
    logic r_ovf;
    logic r_zero;

    // Flags are formed from the final stage's inputs so they register together with the last slice.
    assign w_ovf  = (g_stage[LAST].w_a[CHUNK-1] == g_stage[LAST].w_b[CHUNK-1]) &&
                    (g_stage[LAST].w_res[WIDTH-1] != g_stage[LAST].w_a[CHUNK-1]);
    assign w_zero = (g_stage[LAST].w_res == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign overflow_o = r_ovf;
    assign zero_o     = r_zero;
`else
    assign overflow_o = 1'b0;
    assign zero_o     = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed corner cases, stall/reset scenarios and a
// randomized stream scored against an integer-arithmetic reference model.

module tb_adder_pipe;

    localparam int W      = 32;
    localparam int STAGES = 4;
`ifdef ADDER_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i, in_ready_o, sub_i, carry_i;
    logic [31:0] a_i, b_i, res_o;
    logic        out_valid_o, out_ready_i, carry_o, overflow_o, zero_o;

    logic       in_valid4, in_ready4, sub4, carry4, out_valid4, carry_o4, ovf4, zero4;
    logic [3:0] a4, b4, res4;

    adder_pipe #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sub_i(sub_i), .carry_i(carry_i), .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .res_o(res_o), .carry_o(carry_o), .overflow_o(overflow_o),
        .zero_o(zero_o)
    );

    adder_pipe #(.WIDTH(4), .CHUNK(1)) u_dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .sub_i(sub4), .carry_i(carry4), .a_i(a4), .b_i(b4), .out_valid_o(out_valid4),
        .out_ready_i(1'b1), .res_o(res4), .carry_o(carry_o4), .overflow_o(ovf4), .zero_o(zero4)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [34:0] q[$];
    logic        stall_prev = 1'b0;
    logic [34:0] prev_out, cur_out;
    logic        seen_valid, seen_ready, seen_acc;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: exact integer arithmetic, then reduce to w bits. Packed as {zero, ovf, carry, res}.
    function automatic logic [34:0] model(int w, longint ua, longint ub, logic sub, logic cin);
        longint m, ci, sa, sb, u, s, rl;
        logic   c, v, z;
        m  = longint'(1) << w;
        ci = longint'(cin);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (sub) begin
            u = ua - ub - ci;
            s = sa - sb - ci;
            c = (u >= 0);
        end else begin
            u = ua + ub + ci;
            s = sa + sb + ci;
            c = (u >= m);
        end
        rl = u & (m - 1);
        v  = (s >= m / 2) || (s < -(m / 2));
        z  = (rl == 0);
        return {z & FLAGS, v & FLAGS, c, rl[31:0]};
    endfunction

    function automatic logic [34:0] exp32(logic [31:0] r, logic c, logic v, logic z);
        return {z & FLAGS, v & FLAGS, c, r};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(logic [31:0] a, logic [31:0] b, logic sub, logic cin);
        a_i = a; b_i = b; sub_i = sub; carry_i = cin;
    endtask

    // One cycle: sample just after the falling edge, score drains, record accepts, advance.
    task automatic tick();
        #1;
        cur_out    = {zero_o, overflow_o, carry_o, res_o};
        seen_valid = out_valid_o;
        seen_ready = in_ready_o;
        seen_acc   = in_valid_i && in_ready_o;
        if (stall_prev) check("hold", cur_out, prev_out);
        if (out_valid_o && out_ready_i) begin
            if (q.size() == 0) check("unexpected_beat", 1, 0);
            else check("result", cur_out, q.pop_front());
        end
        if (seen_acc) q.push_back(model(W, a_i, b_i, sub_i, carry_i));
        stall_prev = out_valid_o && !out_ready_i;
        prev_out   = cur_out;
        @(negedge clk_i);
    endtask

    task automatic send_one(string tag, logic [31:0] a, logic [31:0] b, logic sub, logic cin,
                            logic [34:0] exp);
        int lat;
        drive(a, b, sub, cin);
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        tick();
        check({tag, "_acc"}, seen_acc, 1);
        in_valid_i = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (seen_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, lat, STAGES);
        check(tag, cur_out, exp);
    endtask

    task automatic send4(logic [3:0] a, logic [3:0] b, logic sub, logic cin, logic [34:0] exp);
        int lat;
        a4 = a; b4 = b; sub4 = sub; carry4 = cin; in_valid4 = 1'b1;
        #1 check("w4_ready", in_ready4, 1);
        @(negedge clk_i);
        in_valid4 = 1'b0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            #1;
            if (out_valid4) begin
                lat = n;
                break;
            end
            @(negedge clk_i);
        end
        check("w4_lat", lat, 4);
        check("w4_result", {zero4, ovf4, carry_o4, 28'h0, res4}, exp);
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sa[8], sb[8];
        int          sent;
        logic        any;
        logic [3:0]  ra, rb;
        logic        rs, rc;

        rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; drive(0, 0, 0, 0);
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; carry4 = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_valid", out_valid_o, 0);
        check("rst_res", res_o, 0);
        check("rst_carry", carry_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_zero", zero_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check("ready_after_rst", seen_ready, 1);

        send_one("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, exp32(32'h0, 1, 0, 1));
        send_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, exp32(32'h8000_0000, 0, 1, 0));
        send_one("sub", 32'd5, 32'd7, 1'b1, 1'b0, exp32(32'hFFFF_FFFE, 0, 0, 0));
        send_one("sub_bin", 32'd5, 32'd7, 1'b1, 1'b1, exp32(32'hFFFF_FFFD, 0, 0, 0));

        // Eight back-to-back beats, consumer stalls in cycles 5..7.
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
        end
        sent = 0;
        for (int t = 0; t < 40 && (sent < 8 || q.size() > 0); t++) begin
            in_valid_i = (sent < 8);
            if (sent < 8) drive(sa[sent], sb[sent], sent[0], sent[1]);
            out_ready_i = !(t >= 5 && t <= 7);
            tick();
            if (t <= 9) check("stall_ready", seen_ready, !(t >= 5 && t <= 7));
            if (seen_acc) sent++;
        end
        check("stream_sent", sent, 8);
        check("stream_empty", q.size(), 0);

        // Fill the pipe, then reset asynchronously mid-cycle.
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 1'b0, 1'b0);
            in_valid_i = 1'b1;
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        tick();
        check("fill_valid", seen_valid, 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_valid", out_valid_o, 0);
        check("rst_async_res", res_o, 0);
        q.delete();
        stall_prev = 1'b0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        any = 1'b0;
        repeat (8) begin
            tick();
            any |= seen_valid;
        end
        check("no_stale", any, 0);
        send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, exp32(32'h2345_6789, 0, 0, 0));

        // Randomized traffic with random back-pressure.
        for (int t = 0; t < 400; t++) begin
            in_valid_i = ($urandom_range(0, 3) != 0);
            drive(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) tick();
        check("rand_empty", q.size(), 0);

        // Narrow configuration: one bit per stage.
        send4(4'hF, 4'h1, 1'b0, 1'b1, exp32(32'h1, 1, 0, 0));
        for (int i = 0; i < 6; i++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            send4(ra, rb, rs, rc, model(4, ra, rb, rs, rc));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake. Operands are split into CHUNK-bit slices; each pipeline stage adds one slice and registers the inter-slice carry, so the critical path is CHUNK full-adder cells regardless of WIDTH. It replaces fixed-width combinational adders in datapaths that need wide operands at full clock rate and can tolerate fixed latency, e.g. the ALU add path and address generation.

## Interface

- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per stage; STAGES = WIDTH/CHUNK, at least 1.

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  pipeline accepts a beat this cycle
- sub_i  in  1  0: a+b+carry_i; 1: a-b-carry_i (borrow-in)
- carry_i  in  1  carry/borrow in
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B
- out_valid_o  out  1  result beat valid
- out_ready_i  in  1  consumer accepts result
- res_o  out  WIDTH  sum/difference
- carry_o  out  1  carry out of MSB; for subtract, 1 = no borrow
- overflow_o  out  1  signed two's-complement overflow
- zero_o  out  1  res_o == 0

## Operation

- Beat accepted when in_valid_i && in_ready_o.
- At acceptance: B' = sub_i ? ~b_i : b_i; cin = carry_i ^ sub_i.
- Stage k (0..STAGES-1) adds slice k of A and B' plus the registered carry from stage k-1 (cin for stage 0). It registers the result slices produced so far, the unconsumed upper slices of A and B', the carry, the MSBs of A and B' for flag generation, and a valid bit.
- Final stage drives res_o, carry_o and the flags from registers; no combinational path from inputs to outputs.
- overflow_o = (A[MSB] == B'[MSB]) && (res_o[MSB] != A[MSB]).
- Results are arithmetic mod 2^WIDTH; carry_o is the (WIDTH+1)-th bit.
- Global stall: stall = out_valid_o && !out_ready_i. When stalled, every stage register holds. in_ready_o = !stall.
- Bubbles (invalid stages) advance normally; the pipeline has no state machine beyond per-stage valid bits.
- Beats leave in acceptance order; none are dropped or duplicated.

## Timing

- Latency: a beat accepted at edge N appears with out_valid_o high after edge N+STAGES, assuming no stall.
- Throughput: one beat per cycle while out_ready_i is high.
- in_ready_o is combinational from out_ready_i and out_valid_o only, never from in_valid_i.
- While out_valid_o && !out_ready_i, res_o, carry_o, overflow_o and zero_o hold stable.
- Simultaneous accept and drain in the same cycle is legal and sustains full rate.
- Reset value: all valid bits 0, out_valid_o 0, res_o 0, carry_o 0, overflow_o 0, zero_o 0; in_ready_o 1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight beats immediately and asynchronously; no partial result is ever presented.
- STAGES == 1: single registered adder with the same handshake.

## Configuration

- ADDER_PIPE_FLAGS_EN defined: overflow_o and zero_o are computed and registered as specified.
- Not defined: overflow_o and zero_o are tied to 0, flag pipeline registers are omitted, and the ports remain present. res_o, carry_o and the handshake are unchanged.

## Test plan

- WIDTH=32, CHUNK=8, add 0xFFFFFFFF + 0x00000001, carry_i=0 -> 4 cycles later res_o=0x00000000, carry_o=1, zero_o=1, overflow_o=0.
- Add 0x7FFFFFFF + 0x00000001 -> res_o=0x80000000, carry_o=0, overflow_o=1, zero_o=0.
- sub_i=1, 5 - 7, carry_i=0 -> res_o=0xFFFFFFFE, carry_o=0, overflow_o=0; with carry_i=1 -> res_o=0xFFFFFFFD.
- Stream 8 back-to-back beats with out_ready_i low for 3 cycles mid-stream -> in_ready_o low for exactly those stall cycles, outputs held, all 8 results in order, no loss.
- Fill the pipe with 4 beats, pulse rst_ni low mid-cycle -> out_valid_o drops at once, no stale beat after release, next accepted beat correct with latency 4.
- WIDTH=4, CHUNK=1, add 0xF + 0x1, carry_i=1 -> 4 cycles later res_o=0x1, carry_o=1, overflow_o=0.
